// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM states,
// legal width range and bit-counter sizing.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle of the serial adder: start handshake, operands in,
// registered result and status out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder_fa_bit.sv
// One-bit combinational full-adder slice.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice and a
// registered carry walk the operands LSB first, result returned in parallel.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of supported range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             s_bit, c_next;

  fa_bit u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .s    (s_bit),
    .cout (c_next)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        sr_d    = {s_bit, sr_q[WIDTH-1:1]};
        carry_d = c_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = {s_bit, sr_q[WIDTH-1:1]};
          cout_d  = c_next;
          // carry_q here is the carry into the MSB slice
          ovf_d   = carry_q ^ c_next;
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.start) begin
          // subtraction is a + ~b + 1: the +1 rides in as the initial carry
          sa_d    = bus.a;
          sb_d    = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed and random
// operations checked against an integer-arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_sum, prev_sum;
  logic       exp_c, exp_o, prev_c, prev_o;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  task automatic model(input logic [7:0] x, input logic [7:0] y, input logic s,
                       output logic [7:0] r, output logic c, output logic o);
    int ua, ub, sa, sb, ures, sres;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    ures = s ? (ua - ub) : (ua + ub);
    sres = s ? (sa - sb) : (sa + sb);
    r = 8'(ures);
    c = s ? (ua >= ub) : (ures > 255);
    o = (sres > 127) || (sres < -128);
  endtask

  task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic s);
    bus.a     = x;
    bus.b     = y;
    bus.sub   = s;
    bus.start = 1'b1;
    model(x, y, s, exp_sum, exp_c, exp_o);
  endtask

  // Called #1 after the edge that sampled start, with start already low.
  task automatic wait_done(input string tag);
    int lat, nbusy;
    bit found, hold_ok;
    found   = 0;
    lat     = 99;
    hold_ok = 1;
    nbusy   = int'(bus.busy);
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        found = 1;
        lat   = i;
      end else begin
        if (bus.busy) nbusy++;
        if (bus.sum !== prev_sum || bus.carry_out !== prev_c || bus.overflow !== prev_o)
          hold_ok = 0;
      end
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_busy_cycles"}, nbusy, 8);
    check({tag, "_busy_at_done"}, bus.busy, 1'b0);
    check({tag, "_hold_prev"}, hold_ok, 1'b1);
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_carry_out"}, bus.carry_out, exp_c);
    check({tag, "_overflow"}, bus.overflow, exp_o);
    prev_sum = exp_sum;
    prev_c   = exp_c;
    prev_o   = exp_o;
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic s, input string tag);
    launch(x, y, s);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    int ndone, dcyc;
    logic [7:0] cap_sum;
    logic cap_c, cap_o;
    logic [7:0] ra, rb;
    logic rs;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    prev_sum  = '0;
    prev_c    = 1'b0;
    prev_o    = 1'b0;
    #3;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_sum", bus.sum, 8'h00);
    check("reset_flags", {bus.carry_out, bus.overflow}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h5A, 8'h3C, 1'b0, "add");
    do_op(8'hFF, 8'h01, 1'b0, "wrap");
    do_op(8'h10, 8'h20, 1'b1, "sub_borrow");
    do_op(8'h80, 8'h01, 1'b1, "sub_ovf");

    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      do_op(ra, rb, rs, "rand");
    end

    // start already high in the DONE cycle: next op begins immediately
    do_op(8'h11, 8'h22, 1'b0, "b2b_first");
    launch(8'hC0, 8'h50, 1'b1);
    @(posedge clk); #1;
    check("b2b_busy_rise", bus.busy, 1'b1);
    check("b2b_no_done", bus.done, 1'b0);
    bus.start = 1'b0;
    wait_done("b2b_second");

    // start pulses during RUN must be ignored
    @(posedge clk); #1;
    launch(8'h33, 8'h44, 1'b0);
    @(posedge clk); #1;
    ndone = 0;
    dcyc  = 0;
    cap_sum = '0;
    cap_c = 1'b0;
    cap_o = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3 || c == 5) begin
        bus.start = 1'b1;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.sub   = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        dcyc    = c;
        cap_sum = bus.sum;
        cap_c   = bus.carry_out;
        cap_o   = bus.overflow;
      end
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_done_cycle", dcyc, 8);
    check("ignore_sum", cap_sum, exp_sum);
    check("ignore_flags", {cap_c, cap_o}, {exp_c, exp_o});
    prev_sum = exp_sum;
    prev_c   = exp_c;
    prev_o   = exp_o;

    // reset asserted mid-RUN clears outputs without a clock edge
    launch(8'h7F, 8'h7F, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_sum", bus.sum, 8'h00);
    check("midrst_flags", {bus.carry_out, bus.overflow}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    check("midrst_no_activity", ndone, 0);
    prev_sum = '0;
    prev_c   = 1'b0;
    prev_o   = 1'b0;
    do_op(8'h01, 8'h01, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
